// File: rtl/spin_pkg.sv
// Shared types and widths for the spin encoder: direction states, sample format, delta sign extension.
package spin_pkg;

  localparam int unsigned POS_W   = 8;
  localparam int unsigned DELTA_W = 8;
  localparam int unsigned SPIN_W  = DELTA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dir_e;

  // One analog sample: toggle flags a new sample, delta is a signed step.
  typedef struct packed {
    logic               toggle;
    logic [DELTA_W-1:0] delta;
  } spin_sample_t;

  function automatic logic [POS_W-1:0] sext_delta(input logic [DELTA_W-1:0] d);
    return POS_W'($signed(d));
  endfunction

endpackage

// File: rtl/spin_encoder_if.sv
// Control and sample bundle between the input front-end and the spin encoder.
interface spin_encoder_if;
  import spin_pkg::*;

  logic               minus;
  logic               plus;
  logic               fast;
  logic               strobe;
  spin_sample_t       spin1_in;
  spin_sample_t       spin2_in;
  logic [POS_W-1:0]   spin_out;

  modport master (
    output minus, plus, fast, strobe, spin1_in, spin2_in,
    input  spin_out
  );

  modport slave (
    input  minus, plus, fast, strobe, spin1_in, spin2_in,
    output spin_out
  );
endinterface

// File: rtl/spin_delta_capture.sv
// Accepts one analog sample per toggle of its flag bit and presents the sign-extended delta for that cycle.
module spin_delta_capture
  import spin_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  spin_sample_t     spin_in,
  output logic [POS_W-1:0] delta_c
);

  logic prev_q;
  logic primed_q;

  // First cycle out of reset only learns the flag level, so a held-high flag is not a sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= spin_in.toggle;
      primed_q <= 1'b1;
    end
  end

  assign delta_c = (primed_q && (spin_in.toggle != prev_q)) ? sext_delta(spin_in.delta)
                                                             : '0;

endmodule

// File: rtl/spin_encoder.sv
// Spinner position encoder: digital joystick stepping per frame plus two analog delta sources, wrapping 8-bit.
// Optional frame-hold acceleration is enabled with SPIN_ENCODER_ACCEL_EN.
module spin_encoder
  import spin_pkg::*;
#(
  parameter int unsigned SLOW_STEP   = 5,
  parameter int unsigned FAST_STEP   = 15,
  parameter int unsigned RAMP_FRAMES = 25
) (
  input  logic           clk,
  input  logic           reset_n,
  spin_encoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_INC  = INC;
  localparam logic [1:0] S_DEC  = DEC;

  if (RAMP_FRAMES == 0) begin : g_ramp_chk
    $error("RAMP_FRAMES must be at least 1");
  end

  logic [1:0]       state_q, state_nxt;
  logic             strobe_q;
  logic             edge_c;
  logic             fast_sel;
  logic [POS_W-1:0] mag;
  logic [POS_W-1:0] dig_c;
  logic [POS_W-1:0] d1_c, d2_c;
  logic [POS_W-1:0] acc_q, acc_nxt;

`ifdef SPIN_ENCODER_ACCEL_EN
  localparam int unsigned HOLD_W = $clog2(RAMP_FRAMES + 1);
  logic [HOLD_W-1:0] hold_q, hold_nxt;
`endif

  assign edge_c = bus.strobe & ~strobe_q;

  spin_delta_capture u_cap1 (
    .clk     (clk),
    .reset_n (reset_n),
    .spin_in (bus.spin1_in),
    .delta_c (d1_c)
  );

  spin_delta_capture u_cap2 (
    .clk     (clk),
    .reset_n (reset_n),
    .spin_in (bus.spin2_in),
    .delta_c (d2_c)
  );

  // Direction decision and digital step; the step reflects the state being entered at this edge.
  always_comb begin : next_c
    state_nxt = state_q;
    fast_sel  = 1'b0;
    mag       = '0;
    dig_c     = '0;
`ifdef SPIN_ENCODER_ACCEL_EN
    hold_nxt  = hold_q;
`endif
    if (edge_c) begin
      if (bus.plus && !bus.minus) begin
        state_nxt = S_INC;
      end else if (bus.minus && !bus.plus) begin
        state_nxt = S_DEC;
      end else begin
        state_nxt = S_IDLE;
      end

`ifdef SPIN_ENCODER_ACCEL_EN
      // Entering a state (including a reversal) restarts the hold count; IDLE never counts.
      if ((state_nxt != state_q) || (state_nxt == S_IDLE)) begin
        hold_nxt = '0;
      end else if (hold_q != HOLD_W'(RAMP_FRAMES)) begin
        hold_nxt = hold_q + HOLD_W'(1);
      end
      fast_sel = bus.fast || (hold_nxt == HOLD_W'(RAMP_FRAMES));
`else
      fast_sel = bus.fast;
`endif

      mag = fast_sel ? POS_W'(FAST_STEP) : POS_W'(SLOW_STEP);

      case (state_nxt)
        S_INC:   dig_c = mag;
        S_DEC:   dig_c = -mag;
        default: dig_c = '0;
      endcase
    end
  end

  // All contributions of a cycle land together; the sum wraps modulo 2^POS_W.
  assign acc_nxt = acc_q + dig_c + d1_c + d2_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      strobe_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_nxt;
      strobe_q <= bus.strobe;
      acc_q    <= acc_nxt;
    end
  end

`ifdef SPIN_ENCODER_ACCEL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_nxt;
    end
  end
`endif

  assign bus.spin_out = acc_q;

endmodule
